// File: rtl/i2s_adc_frame_tx_pkg.sv
// Shared constants, slot-state encoding and the PCM-to-slot-word helper
// for the I2S ADC-side frame transmitter.
package aud_i2s_pkg;

    localparam int ALIGN_MSB      = 0;
    localparam int ALIGN_LSB      = 1;
    localparam int UNDERRUN_CNT_W = 16;

    typedef enum logic [1:0] {
        SLOT_IDLE  = 2'd0,
        SLOT_LEFT  = 2'd1,
        SLOT_RIGHT = 2'd2
    } slot_state_e;

    // Expands a two's-complement sample of sample_w bits into a slot_w-bit slot word.
    function automatic logic [31:0] slot_word(
        input logic [31:0] sample,
        input int          sample_w,
        input int          slot_w,
        input int          align
    );
        logic [31:0] s_mask;
        logic [31:0] w_mask;
        logic [31:0] word;
        s_mask = (sample_w >= 32'sd32) ? 32'hFFFF_FFFF : ((32'd1 << sample_w) - 32'd1);
        w_mask = (slot_w >= 32'sd32) ? 32'hFFFF_FFFF : ((32'd1 << slot_w) - 32'd1);
        if (align == ALIGN_LSB) begin
            word = sample & s_mask;
            if (sample[sample_w - 1] == 1'b1) begin
                word = word | ~s_mask;
            end else begin
                word = word;
            end
        end else begin
            word = (sample & s_mask) << (slot_w - sample_w);
        end
        return word & w_mask;
    endfunction

endpackage

// File: rtl/i2s_adc_frame_tx_if.sv
// Valid/ready frame write port of the I2S ADC frame transmitter.
interface i2s_adc_frame_tx_if #(
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;

    modport master (output s_valid, output s_data, input s_ready);
    modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/aud_frame_fifo.sv
// Synchronous frame FIFO with registered occupancy and registered not-full flag.
module aud_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level,
    output logic             ready,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [LVL_W-1:0] level_r;
    logic [LVL_W-1:0] level_nxt_s;
    logic             ready_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Qualify accesses and compute the next occupancy.
    always_comb begin
        push_ok_s   = push & ready_r;
        pop_ok_s    = pop & (level_r != '0);
        level_nxt_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_nxt_s = level_r + LVL_W'(1);
            2'b01:   level_nxt_s = level_r - LVL_W'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage array; a same-cycle push and pop touch different slots.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers, level and not-full flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
            ready_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != LVL_W'(DEPTH));
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign level   = level_r;
    assign ready   = ready_r;
    assign empty   = (level_r == '0);

endmodule

// File: rtl/i2s_adc_frame_tx.sv
// Multi-lane I2S ADC-side transmitter: buffers PCM frames and serialises them
// MSB first on the falling bit clock, one BCLK after each LRC transition.
module i2s_adc_frame_tx
    import aud_i2s_pkg::*;
#(
    parameter int NUM_LANES  = 1,
    parameter int SAMPLE_W   = 16,
    parameter int SLOT_W     = 24,
    parameter int ALIGN      = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                            rst_n,
    input  logic                            aud_bclk,
    input  logic                            aud_lrc,
    input  logic                            en,
    input  logic                            hold_last,
    i2s_adc_frame_tx_if.slave               s_if,
    output logic [NUM_LANES-1:0]            aud_adcdat,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            underrun,
    output logic [UNDERRUN_CNT_W-1:0]       underrun_cnt
);
    localparam int FRAME_W = NUM_LANES * 2 * SAMPLE_W;

    logic                      lrc_q_r;
    logic                      left_start_s;
    logic                      right_start_s;
    logic [5:0]                bit_cnt_r;
    logic [4:0]                bit_idx_s;
    logic                      drive_s;
    slot_state_e               state_r;
    slot_state_e               state_nxt_s;
    logic [FRAME_W-1:0]        frame_r;
    logic [FRAME_W-1:0]        frame_nxt_s;
    logic [FRAME_W-1:0]        last_r;
    logic [FRAME_W-1:0]        last_nxt_s;
    logic [FRAME_W-1:0]        fifo_rd_s;
    logic                      fifo_empty_s;
    logic                      pop_s;
    logic                      und_nxt_s;
    logic                      underrun_r;
    logic [UNDERRUN_CNT_W-1:0] ucnt_r;
    logic [NUM_LANES-1:0]      lane_bit_s;
    logic [NUM_LANES-1:0]      adcdat_r;

    aud_frame_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (aud_bclk),
        .rst_n   (rst_n),
        .push    (s_if.s_valid),
        .pop     (pop_s),
        .wr_data (s_if.s_data),
        .rd_data (fifo_rd_s),
        .level   (fifo_level),
        .ready   (s_if.s_ready),
        .empty   (fifo_empty_s)
    );

    assign left_start_s  = lrc_q_r & ~aud_lrc;
    assign right_start_s = ~lrc_q_r & aud_lrc;

    // LRC history and slot bit counter.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            lrc_q_r   <= 1'b0;
            bit_cnt_r <= 6'd0;
        end else begin
            lrc_q_r <= aud_lrc;
            if (left_start_s | right_start_s) begin
                bit_cnt_r <= 6'd0;
            end else if (bit_cnt_r < 6'(SLOT_W)) begin
                bit_cnt_r <= bit_cnt_r + 6'd1;
            end
        end
    end

    // Slot state register.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= SLOT_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Slot state transitions; idle keeps the line quiet until a left start.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            SLOT_IDLE: begin
                if (left_start_s) state_nxt_s = SLOT_LEFT;
                else              state_nxt_s = SLOT_IDLE;
            end
            SLOT_LEFT: begin
                if (right_start_s) state_nxt_s = SLOT_RIGHT;
                else               state_nxt_s = SLOT_LEFT;
            end
            SLOT_RIGHT: begin
                if (left_start_s) state_nxt_s = SLOT_LEFT;
                else              state_nxt_s = SLOT_RIGHT;
            end
            default: state_nxt_s = SLOT_IDLE;
        endcase
    end

    // Frame selection at left start: fresh frame, held frame, or silence.
    always_comb begin
        frame_nxt_s = frame_r;
        last_nxt_s  = last_r;
        und_nxt_s   = 1'b0;
        pop_s       = 1'b0;
        if (left_start_s) begin
            if (!en) begin
                frame_nxt_s = '0;
            end else if (!fifo_empty_s) begin
                pop_s       = 1'b1;
                frame_nxt_s = fifo_rd_s;
                last_nxt_s  = fifo_rd_s;
            end else begin
                und_nxt_s   = 1'b1;
                frame_nxt_s = hold_last ? last_r : '0;
            end
        end else begin
            frame_nxt_s = frame_r;
        end
    end

    // Frame registers and underrun statistics.
    always_ff @(posedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_r    <= '0;
            last_r     <= '0;
            underrun_r <= 1'b0;
            ucnt_r     <= '0;
        end else begin
            frame_r    <= frame_nxt_s;
            last_r     <= last_nxt_s;
            underrun_r <= und_nxt_s;
            if (und_nxt_s && (ucnt_r != {UNDERRUN_CNT_W{1'b1}})) begin
                ucnt_r <= ucnt_r + UNDERRUN_CNT_W'(1);
            end
        end
    end

    assign bit_idx_s = 5'(SLOT_W - 1) - bit_cnt_r[4:0];
    assign drive_s   = (state_r != SLOT_IDLE) && (bit_cnt_r < 6'(SLOT_W));

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [SAMPLE_W-1:0] smp_s;
        logic [31:0]         word_s;

        // Pick this lane's channel for the active slot and form its slot word.
        always_comb begin
            if (state_r == SLOT_RIGHT) begin
                smp_s = frame_r[(2*k+1)*SAMPLE_W +: SAMPLE_W];
            end else begin
                smp_s = frame_r[(2*k)*SAMPLE_W +: SAMPLE_W];
            end
            word_s = slot_word(32'(smp_s), SAMPLE_W, SLOT_W, ALIGN);
        end

        assign lane_bit_s[k] = word_s[bit_idx_s];
    end

    // Launch serial data on the falling bit clock; pad past the slot width.
    always_ff @(negedge aud_bclk or negedge rst_n) begin
        if (!rst_n) begin
            adcdat_r <= '0;
        end else if (drive_s) begin
            adcdat_r <= lane_bit_s;
        end else begin
            adcdat_r <= '0;
        end
    end

    assign aud_adcdat   = adcdat_r;
    assign underrun     = underrun_r;
    assign underrun_cnt = ucnt_r;

endmodule

// File: tb/tb_i2s_adc_frame_tx.sv
// Randomised self-checking bench: two transmitter instances (2-lane MSB-aligned
// depth 4, 1-lane LSB-aligned depth 8) against a frame-level reference model.
module tb_i2s_adc_frame_tx;

    logic        aud_bclk  = 1'b0;
    logic        rst_n     = 1'b0;
    logic        aud_lrc   = 1'b1;
    logic        en        = 1'b1;
    logic        hold_last = 1'b0;
    logic        s_valid   = 1'b0;
    logic [63:0] s_data    = 64'd0;

    logic [1:0]  dat0;
    logic        dat1;
    logic [2:0]  lvl0;
    logic [3:0]  lvl1;
    logic        und0;
    logic        und1;
    logic [15:0] ucnt0;
    logic [15:0] ucnt1;

    i2s_adc_frame_tx_if #(.DATA_W(64)) if0 ();
    i2s_adc_frame_tx_if #(.DATA_W(32)) if1 ();

    assign if0.s_valid = s_valid;
    assign if0.s_data  = s_data;
    assign if1.s_valid = s_valid;
    assign if1.s_data  = s_data[31:0];

    i2s_adc_frame_tx #(
        .NUM_LANES(2), .SAMPLE_W(16), .SLOT_W(24), .ALIGN(0), .FIFO_DEPTH(4)
    ) dut0 (
        .rst_n(rst_n), .aud_bclk(aud_bclk), .aud_lrc(aud_lrc), .en(en),
        .hold_last(hold_last), .s_if(if0), .aud_adcdat(dat0), .fifo_level(lvl0),
        .underrun(und0), .underrun_cnt(ucnt0)
    );

    i2s_adc_frame_tx #(
        .NUM_LANES(1), .SAMPLE_W(16), .SLOT_W(24), .ALIGN(1), .FIFO_DEPTH(8)
    ) dut1 (
        .rst_n(rst_n), .aud_bclk(aud_bclk), .aud_lrc(aud_lrc), .en(en),
        .hold_last(hold_last), .s_if(if1), .aud_adcdat(dat1), .fifo_level(lvl1),
        .underrun(und1), .underrun_cnt(ucnt1)
    );

    always #5 aud_bclk = ~aud_bclk;

    // Reference model state
    logic [63:0] q0 [$];
    logic [31:0] q1 [$];
    logic [63:0] last0;
    logic [31:0] last1;
    int          cnt0;
    int          cnt1;

    int total = 0;
    int bad   = 0;

    // Per-frame capture: 0..3 = dut0 L0,R0,L1,R1; 4..5 = dut1 L,R
    logic [23:0] got_w [6];
    logic [23:0] exp_w [6];
    int          got_s [7];
    int          exp_s [7];
    string       snames [7] = '{"und_pulse0", "und_pulse1", "und_cnt0", "und_cnt1",
                                "level0", "level1", "pad_bits"};

    function automatic logic [23:0] exp_word(input logic [15:0] s, input bit lsb);
        int v;
        if (lsb) v = int'($signed(s));
        else     v = int'(s) * 256;
        return 24'(v);
    endfunction

    task automatic model_reset();
        q0.delete();
        q1.delete();
        last0 = 64'd0;
        last1 = 32'd0;
        cnt0  = 0;
        cnt1  = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aud_bclk);
        #1;
    endtask

    task automatic push_frame(input logic [63:0] d);
        @(negedge aud_bclk);
        s_valid = 1'b1;
        s_data  = d;
        @(posedge aud_bclk);
        if (q0.size() < 4) q0.push_back(d);
        if (q1.size() < 8) q1.push_back(d[31:0]);
        #1;
        s_valid = 1'b0;
    endtask

    // One 64-BCLK frame: model prediction, then drive LRC and capture both slots.
    task automatic run_frame(input logic en_v, input logic hold_v);
        logic [63:0] f0;
        logic [31:0] f1;
        int eu0, eu1, p0, p1, pad;
        eu0 = 0; eu1 = 0; p0 = 0; p1 = 0; pad = 0;
        f0 = 64'd0;
        f1 = 32'd0;
        if (en_v) begin
            if (q0.size() > 0) begin
                f0 = q0.pop_front();
                last0 = f0;
            end else begin
                eu0 = 1;
                if (cnt0 < 65535) cnt0++;
                f0 = hold_v ? last0 : 64'd0;
            end
            if (q1.size() > 0) begin
                f1 = q1.pop_front();
                last1 = f1;
            end else begin
                eu1 = 1;
                if (cnt1 < 65535) cnt1++;
                f1 = hold_v ? last1 : 32'd0;
            end
        end
        for (int k = 0; k < 6; k++) got_w[k] = 24'd0;
        for (int i = 0; i < 64; i++) begin
            @(negedge aud_bclk);
            aud_lrc   = (i >= 32);
            en        = en_v;
            hold_last = hold_v;
            @(posedge aud_bclk);
            #1;
            if (und0) p0++;
            if (und1) p1++;
            if (i >= 1 && i <= 24) begin
                got_w[0] = {got_w[0][22:0], dat0[0]};
                got_w[2] = {got_w[2][22:0], dat0[1]};
                got_w[4] = {got_w[4][22:0], dat1};
            end else if (i >= 33 && i <= 56) begin
                got_w[1] = {got_w[1][22:0], dat0[0]};
                got_w[3] = {got_w[3][22:0], dat0[1]};
                got_w[5] = {got_w[5][22:0], dat1};
            end else if (i >= 25) begin
                if (dat0 !== 2'b00 || dat1 !== 1'b0) pad++;
            end
        end
        exp_w[0] = exp_word(f0[15:0], 1'b0);
        exp_w[1] = exp_word(f0[31:16], 1'b0);
        exp_w[2] = exp_word(f0[47:32], 1'b0);
        exp_w[3] = exp_word(f0[63:48], 1'b0);
        exp_w[4] = exp_word(f1[15:0], 1'b1);
        exp_w[5] = exp_word(f1[31:16], 1'b1);
        got_s = '{p0, p1, int'(ucnt0), int'(ucnt1), int'(lvl0), int'(lvl1), pad};
        exp_s = '{eu0, eu1, cnt0, cnt1, q0.size(), q1.size(), 0};
    endtask

    task automatic test_reset();
        int g [8];
        rst_n = 1'b0;
        model_reset();
        idle(3);
        g = '{int'(dat0), int'(dat1), int'(lvl0), int'(lvl1),
              int'(if0.s_ready), int'(if1.s_ready), int'(und0) + int'(und1),
              int'(ucnt0) + int'(ucnt1)};
        for (int k = 0; k < 8; k++) begin
            total++;
            if (g[k] !== 0) begin
                bad++;
                $display("FAIL reset_value%0d: got %0d want 0", k, g[k]);
            end
        end
        @(negedge aud_bclk);
        rst_n = 1'b1;
        idle(2);
        total++;
        if (if0.s_ready !== 1'b1 || if1.s_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: got %b%b want 11", if0.s_ready, if1.s_ready);
        end
    endtask

    task automatic test_underrun_basic();
        logic [23:0] want [6];
        want = '{24'h800100, 24'h123400, 24'h333300, 24'h444400, 24'hFF8001, 24'h001234};
        push_frame(64'h4444_3333_1234_8001);
        idle(2);
        run_frame(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (got_w[k] !== want[k]) begin
                bad++;
                $display("FAIL basic slot%0d: got %h want %h", k, got_w[k], want[k]);
            end
        end
        for (int k = 0; k < 7; k++) begin
            total++;
            if (got_s[k] !== exp_s[k]) begin
                bad++;
                $display("FAIL basic %s: got %0d want %0d", snames[k], got_s[k], exp_s[k]);
            end
        end
        run_frame(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (got_w[k] !== 24'd0) begin
                bad++;
                $display("FAIL starved slot%0d: got %h want 000000", k, got_w[k]);
            end
        end
        total++;
        if (got_s[0] !== 1 || got_s[1] !== 1 || ucnt0 !== 16'd1 || ucnt1 !== 16'd1) begin
            bad++;
            $display("FAIL starved_underrun: pulses %0d/%0d cnt %0d/%0d want 1/1 1/1",
                     got_s[0], got_s[1], ucnt0, ucnt1);
        end
    endtask

    task automatic test_lanes();
        logic [23:0] want [6];
        want = '{24'h111100, 24'h222200, 24'h333300, 24'h444400, 24'h001111, 24'h002222};
        push_frame(64'h4444_3333_2222_1111);
        idle(1);
        run_frame(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            total++;
            if (got_w[k] !== want[k]) begin
                bad++;
                $display("FAIL lanes slot%0d: got %h want %h", k, got_w[k], want[k]);
            end
        end
    endtask

    task automatic test_hold_last();
        int start0;
        start0 = cnt0;
        push_frame({$urandom, $urandom});
        idle(1);
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b1, 1'b1);
            for (int k = 0; k < 6; k++) begin
                total++;
                if (got_w[k] !== exp_w[k]) begin
                    bad++;
                    $display("FAIL hold f%0d slot%0d: got %h want %h", f, k, got_w[k], exp_w[k]);
                end
            end
        end
        total++;
        if (int'(ucnt0) !== start0 + 2) begin
            bad++;
            $display("FAIL hold_count: got %0d want %0d", ucnt0, start0 + 2);
        end
    endtask

    task automatic test_back_pressure();
        logic [63:0] d;
        for (int i = 0; i < 6; i++) begin
            d = {$urandom, $urandom};
            @(negedge aud_bclk);
            s_valid = 1'b1;
            s_data  = d;
            #1;
            total++;
            if (if0.s_ready !== (q0.size() < 4) || if1.s_ready !== 1'b1) begin
                bad++;
                $display("FAIL bp_ready push%0d: got %b%b want %b1", i, if0.s_ready,
                         if1.s_ready, (q0.size() < 4));
            end
            @(posedge aud_bclk);
            if (q0.size() < 4) q0.push_back(d);
            if (q1.size() < 8) q1.push_back(d[31:0]);
        end
        #1;
        s_valid = 1'b0;
        idle(2);
        total++;
        if (lvl0 !== 3'd4 || lvl1 !== 4'd6 || if0.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_level: got %0d/%0d rdy %b want 4/6 rdy 0", lvl0, lvl1, if0.s_ready);
        end
        for (int f = 0; f < 6; f++) begin
            run_frame(1'b1, 1'b0);
            for (int k = 0; k < 6; k++) begin
                total++;
                if (got_w[k] !== exp_w[k]) begin
                    bad++;
                    $display("FAIL bp f%0d slot%0d: got %h want %h", f, k, got_w[k], exp_w[k]);
                end
            end
            for (int k = 0; k < 7; k++) begin
                total++;
                if (got_s[k] !== exp_s[k]) begin
                    bad++;
                    $display("FAIL bp f%0d %s: got %0d want %0d", f, snames[k], got_s[k], exp_s[k]);
                end
            end
        end
    endtask

    task automatic test_reset_enable();
        logic [63:0] b;
        push_frame(64'hFFFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 12; i++) begin
            @(negedge aud_bclk);
            aud_lrc = 1'b0;
            en      = 1'b1;
            @(posedge aud_bclk);
            #1;
        end
        total++;
        if (dat0 !== 2'b11 || dat1 !== 1'b1) begin
            bad++;
            $display("FAIL midslot_data: got %b%b want 111", dat0, dat1);
        end
        @(negedge aud_bclk);
        rst_n   = 1'b0;
        aud_lrc = 1'b1;
        #1;
        total++;
        if (dat0 !== 2'b00 || dat1 !== 1'b0 || lvl0 !== 3'd0 || lvl1 !== 4'd0 ||
            if0.s_ready !== 1'b0) begin
            bad++;
            $display("FAIL midslot_reset: dat %b%b lvl %0d/%0d rdy %b want 000 0/0 0",
                     dat0, dat1, lvl0, lvl1, if0.s_ready);
        end
        model_reset();
        idle(3);
        @(negedge aud_bclk);
        rst_n = 1'b1;
        idle(2);
        b = {$urandom, $urandom};
        push_frame(b);
        idle(1);
        for (int f = 0; f < 3; f++) begin
            run_frame(f == 2, 1'b0);
            for (int k = 0; k < 6; k++) begin
                total++;
                if (got_w[k] !== exp_w[k]) begin
                    bad++;
                    $display("FAIL enable f%0d slot%0d: got %h want %h", f, k, got_w[k], exp_w[k]);
                end
            end
            for (int k = 0; k < 7; k++) begin
                total++;
                if (got_s[k] !== exp_s[k]) begin
                    bad++;
                    $display("FAIL enable f%0d %s: got %0d want %0d", f, snames[k], got_s[k], exp_s[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        logic en_r;
        logic hold_r;
        int   n;
        for (int r = 0; r < 10; r++) begin
            n = $urandom_range(0, 2);
            for (int p = 0; p < n; p++) push_frame({$urandom, $urandom});
            idle(1);
            en_r   = ($urandom_range(0, 3) != 0);
            hold_r = 1'($urandom_range(0, 1));
            run_frame(en_r, hold_r);
            for (int k = 0; k < 6; k++) begin
                total++;
                if (got_w[k] !== exp_w[k]) begin
                    bad++;
                    $display("FAIL random r%0d slot%0d: got %h want %h", r, k, got_w[k], exp_w[k]);
                end
            end
            for (int k = 0; k < 7; k++) begin
                total++;
                if (got_s[k] !== exp_s[k]) begin
                    bad++;
                    $display("FAIL random r%0d %s: got %0d want %0d", r, snames[k], got_s[k], exp_s[k]);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_underrun_basic();
        test_lanes();
        test_hold_last();
        test_back_pressure();
        test_reset_enable();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/i2s_adc_frame_tx.md
Name: i2s_adc_frame_tx

Overview:
- Parametrised multi-lane I2S ADC-side transmitter. Serialises buffered PCM frames onto one or more ADCDAT lines, framed by the codec-driven aud_bclk/aud_lrc.
- Generalises the stereo mic stimulus source:
  - configurable sample and slot widths;
  - lane count;
  - MSB- or LSB-alignment;
  - valid/ready frame FIFO input with underrun policy and statistics.
- Sits between the sample producer (testbench player or DSP loopback) and the ANC capture path.

Parameters:
- NUM_LANES, 1: number of serial data lines; lane k carries channel 2k in the left slot and 2k+1 in the right slot.
- SAMPLE_W, 16: bits per PCM sample, two's complement.
- SLOT_W, 24: bits driven per slot, MSB first; SLOT_W >= SAMPLE_W, <= 32.
- ALIGN, 0: 0 = MSB-aligned, LSBs zero-padded; 1 = LSB-aligned, sign-extended.
- FIFO_DEPTH, 8: frame FIFO depth, power of two, >= 2.

Ports:
- rst_n  in  1  async active-low reset
- aud_bclk  in  1  bit clock; all logic in this domain
- aud_lrc  in  1  frame sync from codec; low = left slot
- en  in  1  transmit enable, sampled only at left-slot start
- hold_last  in  1  underrun policy: 0 = send zeros, 1 = resend last frame
- s_valid  in  1  frame write request
- s_ready  out  1  FIFO not full
- s_data  in  NUM_LANES*2*SAMPLE_W  frame; channel c at bits [c*SAMPLE_W +: SAMPLE_W]
- aud_adcdat  out  NUM_LANES  serial data, launched on falling aud_bclk
- fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored
- underrun  out  1  one-cycle pulse per starved frame
- underrun_cnt  out  16  saturating starved-frame count

Behaviour:
Reset:
- Reset is rst_n, asynchronous, active-low; clock is aud_bclk.
- Reset values: aud_adcdat=0, fifo_level=0, s_ready=0 during reset then 1, underrun=0, underrun_cnt=0.
- Reset clears the FIFO, shift registers, last-frame register, bit counter and lrc_q.
- Reset mid-frame: output 0 until the next left-slot start.

Edge detection:
- lrc_q <= aud_lrc on rising aud_bclk.
- Left start when lrc_q=1 and aud_lrc=0; right start when lrc_q=0 and aud_lrc=1. Both are evaluated at the rising edge.

Bit counter:
- bit_cnt (6b) clears to 0 on either start, then increments each rising edge, saturating at SLOT_W.

Frame load at left start:
- If en=1 and FIFO non-empty: pop the head into the frame register and copy it to the last-frame register.
- If en=1 and FIFO empty: raise underrun for that cycle and increment underrun_cnt, saturating at 0xFFFF. Load the last frame if hold_last=1, else zeros.
- If en=0: load zeros, no pop, no underrun.
- Right start: no pop; the right slot uses the frame loaded at the preceding left start. A right start before any left start since reset sends zeros.

Slot word formation per channel:
- ALIGN=0: {sample, (SLOT_W-SAMPLE_W) zeros}.
- ALIGN=1: sign-extend sample to SLOT_W.

Serialisation:
- On falling aud_bclk, drive bit (SLOT_W-1-bit_cnt) of the current slot word when bit_cnt < SLOT_W, else 0.
- This gives the standard I2S one-BCLK MSB delay after the LRC transition.

FIFO:
- Synchronous. Write when s_valid & s_ready.
- A frame written in cycle N is poppable at cycle N+1 or later; no write-to-pop bypass.
- A push and a pop in the same cycle are both honoured (level unchanged).
- When full, s_ready=0 and pushes are ignored.
- fifo_level updates on the edge after the access.

Decomposition:
- Package aud_i2s_pkg:
  - ALIGN_MSB=0 and ALIGN_LSB=1 constants;
  - function slot_word(sample, SAMPLE_W, SLOT_W, ALIGN);
  - UNDERRUN_CNT_W=16.
- Sub-module aud_frame_fifo: parametrised width/depth sync FIFO with level output, instantiated once.

Test Plan:
1. Underrun basic (NUM_LANES=1, SAMPLE_W=16, SLOT_W=24, ALIGN=0, 64 bclk/frame, 32 bclk per slot): push left 0x8001 / right 0x1234 before a left start.
   - Left slot bits = 0x800100 MSB-first starting one bclk after LRC falls, then 8 zeros.
   - Right slot = 0x123400.
   - Next frame with FIFO empty and hold_last=0 → all zeros, underrun pulse, underrun_cnt=1.
2. ALIGN=1, same data → left slot 0xFF8001, right slot 0x001234.
3. hold_last=1, one frame pushed, three frames elapse → frame repeated three times; underrun_cnt=2.
4. Back-pressure (FIFO_DEPTH=4): push 6 frames back-to-back with no LRC → s_ready low after 4 accepted, fifo_level=4. Frames then emerge in order 1..4.
5. Reset/enable: assert rst_n low mid-left-slot → aud_adcdat=0 immediately, level=0. Deassert and set en=0 for 2 frames with data queued → zeros, no pop, no underrun. Set en=1 → queued frame appears at the next left start.
6. NUM_LANES=2 with channels 0x1111, 0x2222, 0x3333, 0x4444 → lane0 carries L=0x1111, R=0x2222; lane1 carries L=0x3333, R=0x4444; both bit-aligned to each other.
